// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions, default widths.
package execute_stage_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned OP_W_DEF   = 4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SETC = 4'd11;
  localparam logic [3:0] OP_CLRC = 4'd12;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

endpackage

// File: rtl/execute_stage_alu16.sv
// Combinational ALU: Rdst <- D op S, with next flag values and write-back suppression.
module execute_stage_alu16
  import execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic [DATA_W-1:0] s_i,
  input  logic [2:0]        flags_i,
  output logic [DATA_W-1:0] result_o,
  output logic [2:0]        flags_o,
  output logic              wb_suppress_o
);

  logic [DATA_W:0] wide;
  logic            upd_zn;

  // Decode opcode; flags not touched by an op pass through from flags_i.
  always_comb begin
    result_o      = d_i;
    flags_o       = flags_i;
    wb_suppress_o = 1'b0;
    upd_zn        = 1'b0;
    wide          = '0;
    case (op_i)
      OP_MOV: result_o = s_i;
      OP_ADD: begin
        wide             = {1'b0, d_i} + {1'b0, s_i};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        upd_zn           = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (D < S unsigned).
        wide             = {1'b0, d_i} - {1'b0, s_i};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        upd_zn           = 1'b1;
      end
      OP_AND: begin
        result_o = d_i & s_i;
        upd_zn   = 1'b1;
      end
      OP_OR: begin
        result_o = d_i | s_i;
        upd_zn   = 1'b1;
      end
      OP_NOT: begin
        result_o = ~d_i;
        upd_zn   = 1'b1;
      end
      OP_INC: begin
        wide             = {1'b0, d_i} + {{DATA_W{1'b0}}, 1'b1};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        upd_zn           = 1'b1;
      end
      OP_DEC: begin
        wide             = {1'b0, d_i} - {{DATA_W{1'b0}}, 1'b1};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        upd_zn           = 1'b1;
      end
      OP_SHL: begin
        result_o         = {d_i[DATA_W-2:0], 1'b0};
        flags_o[FLAG_C]  = d_i[DATA_W-1];
        upd_zn           = 1'b1;
      end
      OP_SHR: begin
        result_o         = {1'b0, d_i[DATA_W-1:1]};
        flags_o[FLAG_C]  = d_i[0];
        upd_zn           = 1'b1;
      end
      OP_SETC: begin
        flags_o[FLAG_C] = 1'b1;
        wb_suppress_o   = 1'b1;
      end
      OP_CLRC: begin
        flags_o[FLAG_C] = 1'b0;
        wb_suppress_o   = 1'b1;
      end
      // NOP and undefined opcodes pass D through without writing back.
      default: wb_suppress_o = 1'b1;
    endcase
    if (upd_zn) begin
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_N] = result_o[DATA_W-1];
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, MEM/WB operand forwarding, ALU, flag register, EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [OP_W-1:0]   id_op_i,
  input  logic [DATA_W-1:0] id_src_data_i,
  input  logic [DATA_W-1:0] id_dst_data_i,
  input  logic [ADDR_W-1:0] id_src_addr_i,
  input  logic [ADDR_W-1:0] id_dst_addr_i,
  input  logic              id_write_back_i,
  input  logic              fwd_mem_en_i,
  input  logic [ADDR_W-1:0] fwd_mem_addr_i,
  input  logic [DATA_W-1:0] fwd_mem_data_i,
  input  logic              fwd_wb_en_i,
  input  logic [ADDR_W-1:0] fwd_wb_addr_i,
  input  logic [DATA_W-1:0] fwd_wb_data_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_result_o,
  output logic [ADDR_W-1:0] ex_dst_addr_o,
  output logic              ex_write_back_o,
  output logic [2:0]        ex_flags_o
);

  logic              idex_valid_q, idex_valid_d;
  logic [OP_W-1:0]   idex_op_q, idex_op_d;
  logic [DATA_W-1:0] idex_src_data_q, idex_src_data_d;
  logic [DATA_W-1:0] idex_dst_data_q, idex_dst_data_d;
  logic [ADDR_W-1:0] idex_src_addr_q, idex_src_addr_d;
  logic [ADDR_W-1:0] idex_dst_addr_q, idex_dst_addr_d;
  logic              idex_wb_q, idex_wb_d;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_result_q, ex_result_d;
  logic [ADDR_W-1:0] ex_dst_addr_q, ex_dst_addr_d;
  logic              ex_wb_q, ex_wb_d;
  logic [2:0]        flags_q, flags_d;

  logic [DATA_W-1:0] src_fwd, dst_fwd;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        alu_flags;
  logic              alu_wb_suppress;

  // ID/EX next state: flush bubbles, stall holds, otherwise load decode outputs.
  always_comb begin
    idex_valid_d    = idex_valid_q;
    idex_op_d       = idex_op_q;
    idex_src_data_d = idex_src_data_q;
    idex_dst_data_d = idex_dst_data_q;
    idex_src_addr_d = idex_src_addr_q;
    idex_dst_addr_d = idex_dst_addr_q;
    idex_wb_d       = idex_wb_q;
    if (flush_i) begin
      idex_valid_d = 1'b0;
      idex_wb_d    = 1'b0;
    end else if (!stall_i) begin
      idex_valid_d    = id_valid_i;
      idex_op_d       = id_op_i;
      idex_src_data_d = id_src_data_i;
      idex_dst_data_d = id_dst_data_i;
      idex_src_addr_d = id_src_addr_i;
      idex_dst_addr_d = id_dst_addr_i;
      idex_wb_d       = id_valid_i & id_write_back_i;
    end
  end

  // Operand forwarding; the MEM stage holds the younger value so it wins over WB.
  always_comb begin
    src_fwd = idex_src_data_q;
    if (fwd_mem_en_i && (fwd_mem_addr_i == idex_src_addr_q)) begin
      src_fwd = fwd_mem_data_i;
    end else if (fwd_wb_en_i && (fwd_wb_addr_i == idex_src_addr_q)) begin
      src_fwd = fwd_wb_data_i;
    end
    dst_fwd = idex_dst_data_q;
    if (fwd_mem_en_i && (fwd_mem_addr_i == idex_dst_addr_q)) begin
      dst_fwd = fwd_mem_data_i;
    end else if (fwd_wb_en_i && (fwd_wb_addr_i == idex_dst_addr_q)) begin
      dst_fwd = fwd_wb_data_i;
    end
  end

  execute_stage_alu16 #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op_i          (idex_op_q),
    .d_i           (dst_fwd),
    .s_i           (src_fwd),
    .flags_i       (flags_q),
    .result_o      (alu_result),
    .flags_o       (alu_flags),
    .wb_suppress_o (alu_wb_suppress)
  );

  // EX/MEM next state: bubble on stall or empty ID/EX (result and address hold).
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_wb_d       = 1'b0;
    ex_result_d   = ex_result_q;
    ex_dst_addr_d = ex_dst_addr_q;
    flags_d       = flags_q;
    if (!stall_i && idex_valid_q) begin
      ex_valid_d    = 1'b1;
      ex_result_d   = alu_result;
      ex_dst_addr_d = idex_dst_addr_q;
      ex_wb_d       = idex_wb_q & ~alu_wb_suppress;
      flags_d       = alu_flags;
    end
  end

  // Pipeline and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idex_valid_q    <= 1'b0;
      idex_op_q       <= OP_NOP;
      idex_src_data_q <= '0;
      idex_dst_data_q <= '0;
      idex_src_addr_q <= '0;
      idex_dst_addr_q <= '0;
      idex_wb_q       <= 1'b0;
      ex_valid_q      <= 1'b0;
      ex_result_q     <= '0;
      ex_dst_addr_q   <= '0;
      ex_wb_q         <= 1'b0;
      flags_q         <= 3'b000;
    end else begin
      idex_valid_q    <= idex_valid_d;
      idex_op_q       <= idex_op_d;
      idex_src_data_q <= idex_src_data_d;
      idex_dst_data_q <= idex_dst_data_d;
      idex_src_addr_q <= idex_src_addr_d;
      idex_dst_addr_q <= idex_dst_addr_d;
      idex_wb_q       <= idex_wb_d;
      ex_valid_q      <= ex_valid_d;
      ex_result_q     <= ex_result_d;
      ex_dst_addr_q   <= ex_dst_addr_d;
      ex_wb_q         <= ex_wb_d;
      flags_q         <= flags_d;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign ex_result_o     = ex_result_q;
  assign ex_dst_addr_o   = ex_dst_addr_q;
  assign ex_write_back_o = ex_wb_q;
  assign ex_flags_o      = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [15:0] id_src_data, id_dst_data;
  logic [2:0]  id_src_addr, id_dst_addr;
  logic        id_write_back;
  logic        fwd_mem_en, fwd_wb_en;
  logic [2:0]  fwd_mem_addr, fwd_wb_addr;
  logic [15:0] fwd_mem_data, fwd_wb_data;
  logic        ex_valid, ex_write_back;
  logic [15:0] ex_result;
  logic [2:0]  ex_dst_addr;
  logic [2:0]  ex_flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_stage u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .flush_i         (flush),
    .id_valid_i      (id_valid),
    .id_op_i         (id_op),
    .id_src_data_i   (id_src_data),
    .id_dst_data_i   (id_dst_data),
    .id_src_addr_i   (id_src_addr),
    .id_dst_addr_i   (id_dst_addr),
    .id_write_back_i (id_write_back),
    .fwd_mem_en_i    (fwd_mem_en),
    .fwd_mem_addr_i  (fwd_mem_addr),
    .fwd_mem_data_i  (fwd_mem_data),
    .fwd_wb_en_i     (fwd_wb_en),
    .fwd_wb_addr_i   (fwd_wb_addr),
    .fwd_wb_data_i   (fwd_wb_data),
    .ex_valid_o      (ex_valid),
    .ex_result_o     (ex_result),
    .ex_dst_addr_o   (ex_dst_addr),
    .ex_write_back_o (ex_write_back),
    .ex_flags_o      (ex_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] s, input logic [15:0] d,
                       input logic [2:0] sa, input logic [2:0] da, input logic wb);
    id_valid      = 1'b1;
    id_op         = op;
    id_src_data   = s;
    id_dst_data   = d;
    id_src_addr   = sa;
    id_dst_addr   = da;
    id_write_back = wb;
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_write_back = 1'b0;
  endtask

  // Issue one op, let it drain through both registers, check result/flags/write-back.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] s,
                        input logic [15:0] d, input logic [15:0] exp_res,
                        input logic [2:0] exp_flags, input logic exp_wb);
    issue(op, s, d, 3'd1, 3'd2, 1'b1);
    step();
    idle();
    step();
    chk({tag, " result"}, ex_result, exp_res);
    chk({tag, " flags"}, ex_flags, exp_flags);
    chk({tag, " wb"}, ex_write_back, exp_wb);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    fwd_mem_en = 1'b0; fwd_mem_addr = '0; fwd_mem_data = '0;
    fwd_wb_en = 1'b0; fwd_wb_addr = '0; fwd_wb_data = '0;
    issue(OP_ADD, 16'h0001, 16'h0002, 3'd1, 3'd2, 1'b1);

    // Reset held two edges with a valid ADD presented
    step();
    step();
    chk("rst valid", ex_valid, 0);
    chk("rst result", ex_result, 0);
    chk("rst flags", ex_flags, 0);
    chk("rst wb", ex_write_back, 0);

    rst_n = 1'b1;
    step();
    chk("post-rst edge1 valid", ex_valid, 0);
    issue(OP_ADD, 16'h0001, 16'hFFFF, 3'd1, 3'd3, 1'b1);
    step();
    chk("first add valid", ex_valid, 1);
    chk("first add result", ex_result, 16'h0003);
    chk("first add flags", ex_flags, 3'b000);
    chk("first add dst", ex_dst_addr, 3'd2);
    idle();
    step();
    chk("add carry result", ex_result, 16'h0000);
    chk("add carry flags", ex_flags, 3'b101);
    chk("add carry dst", ex_dst_addr, 3'd3);
    chk("add carry wb", ex_write_back, 1);

    // Forwarding priority: MEM over WB
    issue(OP_MOV, 16'h1234, 16'h0000, 3'd2, 3'd4, 1'b1);
    step();
    fwd_mem_en = 1'b1; fwd_mem_addr = 3'd2; fwd_mem_data = 16'h0010;
    fwd_wb_en  = 1'b1; fwd_wb_addr  = 3'd2; fwd_wb_data  = 16'h0020;
    idle();
    step();
    chk("fwd mem prio", ex_result, 16'h0010);
    chk("mov flags kept", ex_flags, 3'b101);
    issue(OP_MOV, 16'h1234, 16'h0000, 3'd2, 3'd4, 1'b1);
    step();
    fwd_mem_en = 1'b0;
    idle();
    step();
    chk("fwd wb", ex_result, 16'h0020);
    // Forwarding onto the dst operand
    issue(OP_ADD, 16'h0001, 16'h0100, 3'd5, 3'd2, 1'b1);
    step();
    idle();
    step();
    chk("fwd dst", ex_result, 16'h0021);
    chk("fwd dst flags", ex_flags, 3'b000);
    // src==dst, both forwarded from MEM
    issue(OP_ADD, 16'h0007, 16'h0007, 3'd2, 3'd2, 1'b1);
    step();
    fwd_mem_en = 1'b1;
    idle();
    step();
    chk("fwd src==dst", ex_result, 16'h0020);
    fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;

    // Stall one cycle on SUB 5-7
    issue(OP_SUB, 16'h0007, 16'h0005, 3'd1, 3'd6, 1'b1);
    step();
    idle();
    stall = 1'b1;
    step();
    chk("stall valid", ex_valid, 0);
    chk("stall wb", ex_write_back, 0);
    chk("stall result hold", ex_result, 16'h0020);
    chk("stall flags", ex_flags, 3'b000);
    stall = 1'b0;
    step();
    chk("sub valid", ex_valid, 1);
    chk("sub result", ex_result, 16'hFFFE);
    chk("sub flags", ex_flags, 3'b110);

    // Flush+stall drops the ADD in ID/EX
    issue(OP_ADD, 16'h0001, 16'h0001, 3'd1, 3'd2, 1'b1);
    step();
    flush = 1'b1; stall = 1'b1;
    idle();
    step();
    chk("flush+stall valid", ex_valid, 0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("flushed lost valid", ex_valid, 0);
    chk("flushed flags", ex_flags, 3'b110);

    issue(OP_CLRC, 16'h0000, 16'h0000, 3'd1, 3'd2, 1'b1);
    step();
    issue(OP_SETC, 16'h0000, 16'h0000, 3'd1, 3'd2, 1'b1);
    step();
    chk("clrc flags", ex_flags, 3'b010);
    chk("clrc wb", ex_write_back, 0);
    chk("clrc valid", ex_valid, 1);
    issue(OP_NOT, 16'h0000, 16'h00FF, 3'd1, 3'd2, 1'b1);
    step();
    chk("setc flags", ex_flags, 3'b110);
    chk("setc wb", ex_write_back, 0);
    idle();
    step();
    chk("not result", ex_result, 16'hFF00);
    chk("not flags", ex_flags, 3'b110);
    chk("not wb", ex_write_back, 1);

    // Undefined opcode behaves as NOP
    issue(4'd14, 16'h0000, 16'h1234, 3'd1, 3'd2, 1'b1);
    step();
    idle();
    step();
    chk("op14 valid", ex_valid, 1);
    chk("op14 wb", ex_write_back, 0);
    chk("op14 flags", ex_flags, 3'b110);
    chk("op14 result", ex_result, 16'h1234);

    // Remaining ops; flags chain from the previous op
    run_op("and",   OP_AND, 16'h0FF0, 16'hF0F0, 16'h00F0, 3'b100, 1'b1);
    run_op("or",    OP_OR,  16'h000F, 16'hF000, 16'hF00F, 3'b110, 1'b1);
    run_op("inc0",  OP_INC, 16'h0000, 16'hFFFF, 16'h0000, 3'b101, 1'b1);
    run_op("dec0",  OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 3'b110, 1'b1);
    run_op("shl",   OP_SHL, 16'h0000, 16'h8001, 16'h0002, 3'b100, 1'b1);
    run_op("shr",   OP_SHR, 16'h0000, 16'h0002, 16'h0001, 3'b000, 1'b1);
    run_op("inc1",  OP_INC, 16'h0000, 16'h7FFF, 16'h8000, 3'b010, 1'b1);
    run_op("subeq", OP_SUB, 16'h0009, 16'h0009, 16'h0000, 3'b001, 1'b1);
    run_op("nop",   OP_NOP, 16'h0000, 16'h5555, 16'h5555, 3'b001, 1'b0);

    // Mid-operation reset discards the in-flight instruction
    issue(OP_ADD, 16'h0001, 16'h0001, 3'd1, 3'd2, 1'b1);
    step();
    rst_n = 1'b0;
    idle();
    step();
    chk("midrst valid", ex_valid, 0);
    chk("midrst result", ex_result, 0);
    chk("midrst flags", ex_flags, 0);
    chk("midrst wb", ex_write_back, 0);
    rst_n = 1'b1;
    step();
    chk("midrst drained", ex_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
